mips_inst_encoder: RTL and testbench

//  Assembles MIPS-C instruction words from field-level requests and streams them, with

---
 rtl/mips_enc_if.sv | 37 +++
 rtl/mips_inst_encoder.sv | 172 +++++++++++++++++
 tb/tb_mips_inst_encoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_enc_if.sv
// Request/response bundle between an instruction-word producer and the MIPS encoder.
// The status outputs travel with the bus so the loader sees occupancy and error state.
interface mips_enc_if #(
    parameter int DEPTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_fmt;
    logic [5:0]               req_code;
    logic [4:0]               req_rs;
    logic [4:0]               req_rt;
    logic [4:0]               req_rd;
    logic [4:0]               req_shamt;
    logic [15:0]              req_imm;
    logic [25:0]              req_target;
    logic                     enc_valid;
    logic                     enc_ready;
    logic [31:0]              enc_instr;
    logic [31:0]              enc_addr;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     err_illegal;
    logic [7:0]               illegal_cnt;

    modport master (
        output req_valid, req_fmt, req_code, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, enc_ready,
        input  req_ready, enc_valid, enc_instr, enc_addr, fifo_count, err_illegal,
               illegal_cnt
    );

    modport slave (
        input  req_valid, req_fmt, req_code, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, enc_ready,
        output req_ready, enc_valid, enc_instr, enc_addr, fifo_count, err_illegal,
               illegal_cnt
    );
endinterface

// File: rtl/mips_inst_encoder.sv
// Builds canonical MIPS-C instruction words from field requests and queues them,
// with sequential addresses, for the instruction-memory loader.
module mips_inst_encoder #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0000_3000
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    mips_enc_if.slave bus
);
    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    // Returns {legal, word}; unused fields of legal words are forced to zero.
    function automatic logic [32:0] encode(
        input logic [1:0]  fmt,
        input logic [5:0]  code,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic        ok;
        logic [31:0] w;
        logic [4:0]  s, t, d, sh;
        ok = 1'b0;
        s  = rs;
        t  = rt;
        d  = rd;
        sh = shamt;
        case (fmt)
            2'b00: begin
                case (code)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                    6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: ok = 1'b1;
                    default:      ok = 1'b0;
                endcase
                if (code == 6'h00 || code == 6'h02 || code == 6'h03) s = 5'd0;
                else                                               sh = 5'd0;
                case (code)
                    6'h18, 6'h19, 6'h1A, 6'h1B: d = 5'd0;
                    6'h10, 6'h12: begin s = 5'd0; t = 5'd0; end
                    6'h08, 6'h11, 6'h13: begin t = 5'd0; d = 5'd0; end
                    6'h09:        t = 5'd0;
                    default:      ;
                endcase
                w = {6'h00, s, t, d, sh, code};
            end
            2'b01: begin
                case (code)
                    6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                    6'h25, 6'h28, 6'h29, 6'h2B: ok = 1'b1;
                    default:                    ok = 1'b0;
                endcase
                if (code == 6'h0F)                   s = 5'd0;
                if (code == 6'h06 || code == 6'h07) t = 5'd0;
                w = {code, s, t, imm};
            end
            2'b10: begin
                ok = (code == 6'h00) || (code == 6'h01);
                w  = {6'h01, s, code[4:0], imm};
            end
            default: begin
                ok = (code == 6'h02) || (code == 6'h03);
                w  = {code, target};
            end
        endcase
        return {ok, w};
    endfunction

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      hold_q, hold_d;
    logic             err_q, err_d;
    logic [7:0]       ill_cnt_q, ill_cnt_d;

    logic [32:0] enc_res;
    logic        legal;
    logic [31:0] word;
    logic        flush, accept, push, pop, head_valid;
    logic [31:0] head_word;

    assign enc_res = encode(bus.req_fmt, bus.req_code, bus.req_rs, bus.req_rt,
                            bus.req_rd, bus.req_shamt, bus.req_imm, bus.req_target);
    assign legal   = enc_res[32];
    assign word    = enc_res[31:0];

    assign head_valid = (count_q != '0);
    assign head_word  = mem_q[rd_ptr_q];
    assign flush      = !reset || clear;
    assign accept     = bus.req_valid && (count_q != FULL) && !flush;
    assign push       = accept && legal;
    assign pop        = head_valid && bus.enc_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        err_d     = err_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            addr_d    = START_ADDR;
            hold_d    = '0;
            err_d     = 1'b0;
            ill_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            // The popped word is remembered so enc_instr holds it once the FIFO drains.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + 32'd4;
                hold_d   = head_word;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (accept && !legal) begin
                err_d = 1'b1;
                if (ill_cnt_q != 8'hFF) ill_cnt_d = ill_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= START_ADDR;
            hold_q    <= '0;
            err_q     <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end

    assign bus.req_ready   = (count_q != FULL);
    assign bus.enc_valid   = head_valid;
    assign bus.enc_instr   = head_valid ? head_word : hold_q;
    assign bus.enc_addr    = addr_q;
    assign bus.fifo_count  = count_q;
    assign bus.err_illegal = err_q;
    assign bus.illegal_cnt = ill_cnt_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: directed scenarios plus randomized traffic against
// a queue-based reference model of the encoder and its FIFO.
module tb_mips_inst_encoder;
    logic clk;
    logic reset;
    logic clear;
    logic clear2;
    int   checks;
    int   errors;

    mips_enc_if #(.DEPTH(4)) bus ();
    mips_enc_if #(.DEPTH(2)) bus2 ();

    mips_inst_encoder #(.DEPTH(4), .START_ADDR(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus)
    );

    mips_inst_encoder #(.DEPTH(2), .START_ADDR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    int r_legal[26] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09, 'h10, 'h11,
                        'h12, 'h13, 'h18, 'h19, 'h1A, 'h1B, 'h20, 'h21, 'h22, 'h23,
                        'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int i_legal[20] = '{'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D,
                        'h0E, 'h0F, 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};

    // Reference: field packing by arithmetic, legality and zeroing by mnemonic groups.
    function automatic logic [32:0] model(input int f, input int c, input int rs,
                                          input int rt, input int rd, input int sh,
                                          input int imm, input int tgt);
        logic ok;
        longint w;
        ok = 1'b0;
        w  = 0;
        if (f == 0) begin
            ok = c inside {'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09, 'h10, 'h11,
                           'h12, 'h13, ['h18:'h1B], ['h20:'h27], 'h2A, 'h2B};
            if (c inside {'h00, 'h02, 'h03, 'h10, 'h12}) rs = 0;
            if (!(c inside {'h00, 'h02, 'h03}))          sh = 0;
            if (c inside {'h10, 'h12, 'h11, 'h13, 'h08, 'h09}) rt = 0;
            if (c inside {['h18:'h1B], 'h11, 'h13, 'h08})      rd = 0;
            w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + c;
        end else if (f == 1) begin
            ok = c inside {['h04:'h0F], 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};
            if (c == 'h0F)         rs = 0;
            if (c inside {6, 7})   rt = 0;
            w = c * 67108864 + rs * 2097152 + rt * 65536 + imm;
        end else if (f == 2) begin
            ok = c inside {0, 1};
            w = 67108864 + rs * 2097152 + (c % 32) * 65536 + imm;
        end else begin
            ok = c inside {2, 3};
            w = c * 67108864 + tgt;
        end
        return {ok, w[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int f, input int c, input int rs, input int rt,
                             input int rd, input int sh, input int imm, input int tgt);
        bus.req_valid  = 1'b1;
        bus.req_fmt    = 2'(f);
        bus.req_code   = 6'(c);
        bus.req_rs     = 5'(rs);
        bus.req_rt     = 5'(rt);
        bus.req_rd     = 5'(rd);
        bus.req_shamt  = 5'(sh);
        bus.req_imm    = 16'(imm);
        bus.req_target = 26'(tgt);
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;  bus.req_fmt = '0;    bus.req_code = '0;
        bus.req_rs = '0;       bus.req_rt = '0;     bus.req_rd = '0;
        bus.req_shamt = '0;    bus.req_imm = '0;    bus.req_target = '0;
        bus.enc_ready = 1'b0;  clear = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_fmt = '0;   bus2.req_code = '0;
        bus2.req_rs = '0;      bus2.req_rt = '0;    bus2.req_rd = '0;
        bus2.req_shamt = '0;   bus2.req_imm = '0;   bus2.req_target = '0;
        bus2.enc_ready = 1'b0; clear2 = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        drive_req(0, 'h21, 1, 2, 3, 0, 0, 0);
        tick();
        checks += 7;
        if (bus.enc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.enc_valid); end
        if (bus.enc_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.enc_instr); end
        if (bus.enc_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr got %h exp 3000", bus.enc_addr); end
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.fifo_count); end
        if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err_illegal); end
        if (bus.illegal_cnt !== 8'h0) begin errors++; $display("FAIL rst_icnt got %h exp 0", bus.illegal_cnt); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        apply_reset();
        drive_req(0, 'h21, 1, 2, 3, 7, 0, 0);
        tick();
        bus.req_valid = 1'b0;
        checks += 4;
        if (bus.enc_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.enc_valid); end
        if (bus.enc_instr !== 32'h0022_1821) begin errors++; $display("FAIL basic_instr got %h exp 00221821", bus.enc_instr); end
        if (bus.enc_addr !== 32'h3000) begin errors++; $display("FAIL basic_addr got %h exp 3000", bus.enc_addr); end
        if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", bus.fifo_count); end
        bus.enc_ready = 1'b1;
        tick();
        bus.enc_ready = 1'b0;
        checks += 3;
        if (bus.enc_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", bus.enc_valid); end
        if (bus.enc_instr !== 32'h0022_1821) begin errors++; $display("FAIL basic_hold got %h exp 00221821", bus.enc_instr); end
        if (bus.enc_addr !== 32'h3004) begin errors++; $display("FAIL basic_addr2 got %h exp 3004", bus.enc_addr); end
        tick();
        checks += 1;
        if (bus.enc_addr !== 32'h3004) begin errors++; $display("FAIL basic_noadv got %h exp 3004", bus.enc_addr); end
    endtask

    task automatic test_lui_jal();
        apply_reset();
        drive_req(1, 'h0F, 5, 4, 0, 0, 'h1234, 0);
        tick();
        drive_req(3, 'h03, 0, 0, 0, 0, 0, 'h0C00);
        tick();
        bus.req_valid = 1'b0;
        checks += 3;
        if (bus.enc_instr !== 32'h3C04_1234) begin errors++; $display("FAIL lui_instr got %h exp 3C041234", bus.enc_instr); end
        if (bus.enc_addr !== 32'h3000) begin errors++; $display("FAIL lui_addr got %h exp 3000", bus.enc_addr); end
        if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL lui_count got %0d exp 2", bus.fifo_count); end
        bus.enc_ready = 1'b1;
        tick();
        bus.enc_ready = 1'b0;
        checks += 2;
        if (bus.enc_instr !== 32'h0C00_0C00) begin errors++; $display("FAIL jal_instr got %h exp 0C000C00", bus.enc_instr); end
        if (bus.enc_addr !== 32'h3004) begin errors++; $display("FAIL jal_addr got %h exp 3004", bus.enc_addr); end
    endtask

    task automatic test_full();
        logic [31:0] exp_w;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(0, 'h21, 1, 2, i, 0, 0, 0);
            tick();
        end
        checks += 2;
        if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", bus.fifo_count); end
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.req_ready); end
        drive_req(0, 'h21, 1, 2, 4, 0, 0, 0);
        tick();
        checks += 2;
        if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_hold got %0d exp 4", bus.fifo_count); end
        if (bus.enc_instr !== 32'h0022_0021) begin errors++; $display("FAIL full_head got %h exp 00220021", bus.enc_instr); end
        bus.enc_ready = 1'b1;
        tick();
        checks += 2;
        if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL full_popnopush got %0d exp 3", bus.fifo_count); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready2 got %b exp 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        checks += 1;
        if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL full_pushpop got %0d exp 3", bus.fifo_count); end
        for (int i = 2; i < 5; i++) begin
            exp_w = 32'h0022_0021 | (32'(i) << 11);
            checks += 1;
            if (bus.enc_instr !== exp_w) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, bus.enc_instr, exp_w); end
            tick();
        end
        bus.enc_ready = 1'b0;
        checks += 2;
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", bus.fifo_count); end
        if (bus.enc_addr !== 32'h3014) begin errors++; $display("FAIL full_addr got %h exp 3014", bus.enc_addr); end
    endtask

    task automatic test_illegal();
        apply_reset();
        drive_req(0, 'h3F, 1, 2, 3, 0, 0, 0);
        tick();
        drive_req(2, 'h05, 1, 0, 0, 0, 'h10, 0);
        tick();
        bus.req_valid = 1'b0;
        checks += 4;
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL ill_count got %0d exp 0", bus.fifo_count); end
        if (bus.enc_valid !== 1'b0) begin errors++; $display("FAIL ill_valid got %b exp 0", bus.enc_valid); end
        if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", bus.err_illegal); end
        if (bus.illegal_cnt !== 8'd2) begin errors++; $display("FAIL ill_cnt got %0d exp 2", bus.illegal_cnt); end
    endtask

    task automatic test_clear();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 'h23, 1, 2, 0, 0, i, 0);
            tick();
        end
        drive_req(3, 'h3F, 0, 0, 0, 0, 0, 0);
        tick();
        bus.req_valid = 1'b0;
        bus.enc_ready = 1'b1;
        tick();
        bus.enc_ready = 1'b0;
        checks += 3;
        if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL clr_pre_count got %0d exp 2", bus.fifo_count); end
        if (bus.enc_addr !== 32'h3004) begin errors++; $display("FAIL clr_pre_addr got %h exp 3004", bus.enc_addr); end
        if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL clr_pre_err got %b exp 1", bus.err_illegal); end
        clear = 1'b1;
        bus.enc_ready = 1'b1;
        drive_req(0, 'h20, 1, 2, 3, 0, 0, 0);
        tick();
        clear = 1'b0;
        bus.enc_ready = 1'b0;
        bus.req_valid = 1'b0;
        checks += 6;
        if (bus.enc_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", bus.enc_valid); end
        if (bus.enc_addr !== 32'h3000) begin errors++; $display("FAIL clr_addr got %h exp 3000", bus.enc_addr); end
        if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL clr_err got %b exp 0", bus.err_illegal); end
        if (bus.illegal_cnt !== 8'd0) begin errors++; $display("FAIL clr_icnt got %0d exp 0", bus.illegal_cnt); end
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", bus.fifo_count); end
        if (bus.enc_instr !== 32'h0) begin errors++; $display("FAIL clr_instr got %h exp 0", bus.enc_instr); end
        drive_req(3, 'h02, 0, 0, 0, 0, 0, 'h0000_040);
        tick();
        bus.req_valid = 1'b0;
        checks += 2;
        if (bus.enc_addr !== 32'h3000) begin errors++; $display("FAIL clr_next_addr got %h exp 3000", bus.enc_addr); end
        if (bus.enc_instr !== 32'h0800_0040) begin errors++; $display("FAIL clr_next_instr got %h exp 08000040", bus.enc_instr); end
    endtask

    task automatic test_saturate();
        apply_reset();
        drive_req(3, 'h3F, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 254; i++) tick();
        checks += 1;
        if (bus.illegal_cnt !== 8'hFE) begin errors++; $display("FAIL sat_254 got %h exp FE", bus.illegal_cnt); end
        for (int i = 0; i < 46; i++) tick();
        bus.req_valid = 1'b0;
        checks += 2;
        if (bus.illegal_cnt !== 8'hFF) begin errors++; $display("FAIL sat_300 got %h exp FF", bus.illegal_cnt); end
        if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL sat_count got %0d exp 0", bus.fifo_count); end
    endtask

    task automatic test_addr_wrap();
        apply_reset();
        bus2.req_valid = 1'b1;
        bus2.req_fmt   = 2'b11;
        bus2.req_code  = 6'h02;
        for (int i = 0; i < 2; i++) begin
            bus2.req_target = 26'(i + 1);
            tick();
        end
        bus2.req_valid = 1'b0;
        checks += 3;
        if (bus2.fifo_count !== 2'd2) begin errors++; $display("FAIL wrap_count got %0d exp 2", bus2.fifo_count); end
        if (bus2.req_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready got %b exp 0", bus2.req_ready); end
        if (bus2.enc_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0 got %h exp FFFFFFF8", bus2.enc_addr); end
        bus2.enc_ready = 1'b1;
        tick();
        checks += 2;
        if (bus2.enc_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1 got %h exp FFFFFFFC", bus2.enc_addr); end
        if (bus2.enc_instr !== 32'h0800_0002) begin errors++; $display("FAIL wrap_w1 got %h exp 08000002", bus2.enc_instr); end
        bus2.req_valid  = 1'b1;
        bus2.req_target = 26'd3;
        tick();
        bus2.req_valid = 1'b0;
        checks += 3;
        if (bus2.enc_addr !== 32'h0) begin errors++; $display("FAIL wrap_a2 got %h exp 0", bus2.enc_addr); end
        if (bus2.enc_instr !== 32'h0800_0003) begin errors++; $display("FAIL wrap_w2 got %h exp 08000003", bus2.enc_instr); end
        if (bus2.fifo_count !== 2'd1) begin errors++; $display("FAIL wrap_pp got %0d exp 1", bus2.fifo_count); end
        tick();
        bus2.enc_ready = 1'b0;
        checks += 2;
        if (bus2.enc_addr !== 32'h4) begin errors++; $display("FAIL wrap_a3 got %h exp 4", bus2.enc_addr); end
        if (bus2.enc_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", bus2.enc_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] m_addr, m_last, m_head;
        logic [32:0] res;
        logic        m_err, do_clr, rv, rr, acc;
        int          m_cnt, f, c, rs, rt, rd, sh, imm, tgt;
        apply_reset();
        m_addr = 32'h3000; m_last = 0; m_err = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            f   = int'($urandom_range(3));
            rs  = int'($urandom_range(31)); rt = int'($urandom_range(31));
            rd  = int'($urandom_range(31)); sh = int'($urandom_range(31));
            imm = int'($urandom_range(65535)); tgt = int'($urandom_range(26'h3FF_FFFF));
            if ($urandom_range(3) == 0) c = int'($urandom_range(63));
            else if (f == 0) c = r_legal[$urandom_range(25)];
            else if (f == 1) c = i_legal[$urandom_range(19)];
            else if (f == 2) c = int'($urandom_range(1));
            else             c = 2 + int'($urandom_range(1));
            if (f == 2) c = c % 32;
            rv     = ($urandom_range(3) != 0);
            rr     = ($urandom_range(2) != 0);
            do_clr = ($urandom_range(60) == 0);
            drive_req(f, c, rs, rt, rd, sh, imm, tgt);
            bus.req_valid = rv;
            bus.enc_ready = rr;
            clear         = do_clr;
            m_head = (q.size() != 0) ? q[0] : m_last;
            checks += 7;
            if (bus.enc_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, bus.enc_valid, q.size() != 0); end
            if (bus.enc_instr !== m_head) begin errors++; $display("FAIL rnd_instr c%0d got %h exp %h", cyc, bus.enc_instr, m_head); end
            if (bus.enc_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", cyc, bus.enc_addr, m_addr); end
            if (int'(bus.fifo_count) != q.size()) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", cyc, bus.fifo_count, q.size()); end
            if (bus.req_ready !== (q.size() != 4)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, bus.req_ready, q.size() != 4); end
            if (bus.err_illegal !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, bus.err_illegal, m_err); end
            if (int'(bus.illegal_cnt) != m_cnt) begin errors++; $display("FAIL rnd_icnt c%0d got %0d exp %0d", cyc, bus.illegal_cnt, m_cnt); end
            if (do_clr) begin
                q.delete();
                m_addr = 32'h3000; m_last = 0; m_err = 0; m_cnt = 0;
            end else begin
                acc = rv && (q.size() < 4);
                if (rr && q.size() != 0) begin
                    m_last = q.pop_front();
                    m_addr = m_addr + 32'd4;
                end
                if (acc) begin
                    res = model(f, c, rs, rt, rd, sh, imm, tgt);
                    if (res[32]) q.push_back(res[31:0]);
                    else begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_lui_jal();
        test_full();
        test_illegal();
        test_clear();
        test_saturate();
        test_addr_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
